// File: rtl/wb_stage.sv
// Writeback stage: selects the result source, formats load data, drives the register file
// write port and counts retired instructions.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [4:0]       i_rd,
    input  logic [1:0]       i_wb_sel,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic [XLEN-1:0]  i_pc_plus4,
    input  logic [XLEN-1:0]  i_csr_rdata,
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_addr_lsb,
    input  logic             i_load_ack,
    input  logic [XLEN-1:0]  i_load_data,
    output logic             o_stall,
    output logic             o_wr,
    output logic [4:0]       o_rd,
    output logic [XLEN-1:0]  o_write_data,
    output logic             o_ce,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_instret
);

    localparam logic [1:0] WbAlu  = 2'd0;
    localparam logic [1:0] WbLoad = 2'd1;
    localparam logic [1:0] WbPc4  = 2'd2;

    typedef enum logic [0:0] {
        StIdle,
        StWaitLoad
    } state_e;

    state_e state_q, state_d;

    // Pending-load context held while the memory response is outstanding
    logic [4:0] pend_rd_q, pend_rd_d;
    logic       pend_wr_en_q, pend_wr_en_d;
    logic [2:0] pend_f3_q, pend_f3_d;
    logic [1:0] pend_lsb_q, pend_lsb_d;

    logic             wr_q, wr_d;
    logic             ce_q, ce_d;
    logic             mis_q, mis_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic            capture;
    logic            done;
    logic            use_pend;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_lsb;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;
    logic            ld_mis;
    logic            cmpl_is_load;
    logic            cmpl_mis;
    logic            cmpl_wr_en;
    logic [4:0]      cmpl_rd;
    logic [XLEN-1:0] cmpl_result;

    assign capture = i_ce && !i_flush;

    always_comb begin
        state_d      = state_q;
        pend_rd_d    = pend_rd_q;
        pend_wr_en_d = pend_wr_en_q;
        pend_f3_d    = pend_f3_q;
        pend_lsb_d   = pend_lsb_q;
        done         = 1'b0;
        use_pend     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    if (i_wb_sel == WbLoad && !i_load_ack) begin
                        state_d      = StWaitLoad;
                        pend_rd_d    = i_rd;
                        pend_wr_en_d = i_wr_en;
                        pend_f3_d    = i_funct3;
                        pend_lsb_d   = i_addr_lsb;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            StWaitLoad: begin
                if (i_load_ack) begin
                    done     = 1'b1;
                    use_pend = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Load formatting uses the latched context when completing from WAIT_LOAD
    always_comb begin
        ld_f3  = use_pend ? pend_f3_q : i_funct3;
        ld_lsb = use_pend ? pend_lsb_q : i_addr_lsb;
        unique case (ld_lsb)
            2'd0:    ld_byte = i_load_data[7:0];
            2'd1:    ld_byte = i_load_data[15:8];
            2'd2:    ld_byte = i_load_data[23:16];
            default: ld_byte = i_load_data[31:24];
        endcase
        ld_half = ld_lsb[1] ? i_load_data[31:16] : i_load_data[15:0];
        unique case (ld_f3)
            3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_val = i_load_data;
        endcase
        ld_mis = (ld_f3[1:0] == 2'b01 && ld_lsb[0]) || (ld_f3[1] && ld_lsb != 2'b00);
    end

    always_comb begin
        cmpl_is_load = use_pend || (i_wb_sel == WbLoad);
        cmpl_mis     = cmpl_is_load && ld_mis;
        cmpl_wr_en   = use_pend ? pend_wr_en_q : i_wr_en;
        cmpl_rd      = use_pend ? pend_rd_q : i_rd;
        if (cmpl_is_load) begin
            cmpl_result = ld_val;
        end else begin
            unique case (i_wb_sel)
                WbAlu:   cmpl_result = i_alu_result;
                WbPc4:   cmpl_result = i_pc_plus4;
                default: cmpl_result = i_csr_rdata;
            endcase
        end
    end

    always_comb begin
        wr_d      = done && !cmpl_mis && cmpl_wr_en && (cmpl_rd != 5'd0);
        ce_d      = done && !cmpl_mis;
        mis_d     = done && cmpl_mis;
        rd_d      = wr_d ? cmpl_rd : rd_q;
        wdata_d   = wr_d ? cmpl_result : wdata_q;
        instret_d = ce_d ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pend_rd_q    <= 5'd0;
            pend_wr_en_q <= 1'b0;
            pend_f3_q    <= 3'd0;
            pend_lsb_q   <= 2'd0;
            wr_q         <= 1'b0;
            ce_q         <= 1'b0;
            mis_q        <= 1'b0;
            rd_q         <= 5'd0;
            wdata_q      <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_rd_q    <= pend_rd_d;
            pend_wr_en_q <= pend_wr_en_d;
            pend_f3_q    <= pend_f3_d;
            pend_lsb_q   <= pend_lsb_d;
            wr_q         <= wr_d;
            ce_q         <= ce_d;
            mis_q        <= mis_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
            instret_q    <= instret_d;
        end
    end

    assign o_stall      = (state_q == StWaitLoad);
    assign o_wr         = wr_q;
    assign o_rd         = rd_q;
    assign o_write_data = wdata_q;
    assign o_ce         = ce_q;
    assign o_misaligned = mis_q;
    assign o_instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed test-plan cases plus random traffic against a transaction-level
// model of the writeback stage.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_ce, i_flush, i_wr_en, i_load_ack;
    logic [4:0]  i_rd;
    logic [1:0]  i_wb_sel, i_addr_lsb;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result, i_pc_plus4, i_csr_rdata, i_load_data;
    logic        o_stall, o_wr, o_ce, o_misaligned;
    logic [4:0]  o_rd;
    logic [31:0] o_write_data;
    logic [63:0] o_instret;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .i_ce(i_ce), .i_flush(i_flush), .i_wr_en(i_wr_en),
        .i_rd(i_rd), .i_wb_sel(i_wb_sel), .i_alu_result(i_alu_result),
        .i_pc_plus4(i_pc_plus4), .i_csr_rdata(i_csr_rdata), .i_funct3(i_funct3),
        .i_addr_lsb(i_addr_lsb), .i_load_ack(i_load_ack), .i_load_data(i_load_data),
        .o_stall(o_stall), .o_wr(o_wr), .o_rd(o_rd), .o_write_data(o_write_data), .o_ce(o_ce),
        .o_misaligned(o_misaligned), .o_instret(o_instret)
    );

    int n_checks = 0;
    int n_pass = 0;

    // Model: one outstanding load record plus the expected registered outputs
    logic        m_wait;
    logic [4:0]  m_p_rd;
    logic        m_p_wr;
    logic [2:0]  m_p_f3;
    logic [1:0]  m_p_lsb;
    logic        e_stall, e_wr, e_ce, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [63:0] e_instret;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    endtask

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lsb,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * int'(lsb));
        h = w >> (16 * int'(lsb[1]));
        case (f3)
            3'b000:  return 32'($signed(b[7:0]));
            3'b100:  return 32'(b[7:0]);
            3'b001:  return 32'($signed(h[15:0]));
            3'b101:  return 32'(h[15:0]);
            default: return w;
        endcase
    endfunction

    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        int size;
        size = f3[1] ? 4 : (f3[0] ? 2 : 1);
        return (int'(lsb) % size) != 0;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_p_rd = 0; m_p_wr = 0; m_p_f3 = 0; m_p_lsb = 0;
        e_stall = 0; e_wr = 0; e_ce = 0; e_mis = 0; e_rd = 0; e_wd = 0; e_instret = 0;
    endtask

    // Predicts outputs after the coming rising edge from the inputs just applied
    task automatic model_step();
        logic done, wen, mis;
        logic [4:0] rd;
        logic [31:0] res;
        if (!rst_n) begin
            model_reset();
            return;
        end
        done = 0; wen = 0; mis = 0; rd = 0; res = 0;
        e_wr = 0; e_ce = 0; e_mis = 0;
        if (!m_wait) begin
            if (i_ce && !i_flush) begin
                if (i_wb_sel == 2'd1 && !i_load_ack) begin
                    m_wait = 1; m_p_rd = i_rd; m_p_wr = i_wr_en;
                    m_p_f3 = i_funct3; m_p_lsb = i_addr_lsb;
                end else begin
                    done = 1; wen = i_wr_en; rd = i_rd;
                    case (i_wb_sel)
                        2'd0: res = i_alu_result;
                        2'd1: begin
                            res = load_value(i_funct3, i_addr_lsb, i_load_data);
                            mis = load_misaligned(i_funct3, i_addr_lsb);
                        end
                        2'd2: res = i_pc_plus4;
                        default: res = i_csr_rdata;
                    endcase
                end
            end
        end else if (i_load_ack) begin
            done = 1; m_wait = 0; wen = m_p_wr; rd = m_p_rd;
            res = load_value(m_p_f3, m_p_lsb, i_load_data);
            mis = load_misaligned(m_p_f3, m_p_lsb);
        end
        if (done) begin
            if (mis) begin
                e_mis = 1;
            end else begin
                e_ce = 1;
                e_instret = e_instret + 64'd1;
                if (wen && rd != 0) begin
                    e_wr = 1; e_rd = rd; e_wd = res;
                end
            end
        end
        e_stall = m_wait;
    endtask

    task automatic apply(input logic ce, input logic flush, input logic wen, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [2:0] f3,
                         input logic [1:0] lsb, input logic ack, input logic [31:0] data);
        i_ce = ce; i_flush = flush; i_wr_en = wen; i_rd = rd; i_wb_sel = sel;
        i_alu_result = alu; i_pc_plus4 = $urandom; i_csr_rdata = $urandom;
        i_funct3 = f3; i_addr_lsb = lsb; i_load_ack = ack; i_load_data = data;
        model_step();
    endtask

    task automatic drive(input logic ce, input logic flush, input logic wen, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [2:0] f3,
                         input logic [1:0] lsb, input logic ack, input logic [31:0] data);
        @(negedge clk);
        apply(ce, flush, wen, rd, sel, alu, f3, lsb, ack, data);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        chk("stall", 64'(o_stall), 64'(e_stall));
        chk("wr", 64'(o_wr), 64'(e_wr));
        chk("ce", 64'(o_ce), 64'(e_ce));
        chk("misaligned", 64'(o_misaligned), 64'(e_mis));
        chk("rd", 64'(o_rd), 64'(e_rd));
        chk("write_data", 64'(o_write_data), 64'(e_wd));
        chk("instret", o_instret, e_instret);
    end

    initial begin
        model_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_stall", 64'(o_stall), 64'h0);
        chk("rst_wr", 64'(o_wr), 64'h0);
        chk("rst_ce", 64'(o_ce), 64'h0);
        chk("rst_rd", 64'(o_rd), 64'h0);
        chk("rst_wd", 64'(o_write_data), 64'h0);
        chk("rst_instret", o_instret, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive(1, 0, 1, 5, 0, 32'h1234_5678, 0, 0, 0, 0);
        settle();
        chk("alu_wr", 64'(o_wr), 64'h1);
        chk("alu_rd", 64'(o_rd), 64'h5);
        chk("alu_wd", 64'(o_write_data), 64'h1234_5678);
        chk("alu_ce", 64'(o_ce), 64'h1);
        chk("alu_instret", o_instret, 64'h1);

        drive(1, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        settle();
        chk("rd0_wr", 64'(o_wr), 64'h0);
        chk("rd0_ce", 64'(o_ce), 64'h1);
        drive(1, 1, 1, 7, 0, 32'hCAFE_0000, 0, 0, 0, 0);
        settle();
        chk("flush_wr", 64'(o_wr), 64'h0);
        chk("flush_ce", 64'(o_ce), 64'h0);
        chk("flush_instret", o_instret, 64'h2);

        // LB at lsb 3 with the ack arriving in the third stalled cycle
        drive(1, 0, 1, 9, 1, 0, 3'b000, 3, 0, 32'h80FF_0000);
        settle();
        chk("lb_stall1", 64'(o_stall), 64'h1);
        drive(1, 0, 1, 3, 0, 32'h1111_1111, 0, 0, 0, 0);
        settle();
        chk("lb_stall2", 64'(o_stall), 64'h1);
        chk("lb_wait_ce", 64'(o_ce), 64'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("lb_stall3", 64'(o_stall), 64'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);
        settle();
        chk("lb_stall_end", 64'(o_stall), 64'h0);
        chk("lb_wd", 64'(o_write_data), 64'hFFFF_FF80);
        chk("lb_rd", 64'(o_rd), 64'h9);

        drive(1, 0, 1, 10, 1, 0, 3'b100, 3, 1, 32'h80FF_0000);
        settle();
        chk("lbu_stall", 64'(o_stall), 64'h0);
        chk("lbu_wd", 64'(o_write_data), 64'h0000_0080);
        drive(1, 0, 1, 11, 1, 0, 3'b101, 2, 1, 32'h8001_FFFF);
        settle();
        chk("lhu_wd", 64'(o_write_data), 64'h0000_8001);
        drive(1, 0, 1, 12, 1, 0, 3'b001, 1, 1, 32'h8001_FFFF);
        settle();
        chk("lh_mis", 64'(o_misaligned), 64'h1);
        chk("lh_mis_wr", 64'(o_wr), 64'h0);
        chk("lh_mis_instret", o_instret, 64'h5);

        // Reset during WAIT_LOAD, then a stray ack
        drive(1, 0, 1, 13, 1, 0, 3'b010, 0, 0, 0);
        settle();
        chk("rstw_stall", 64'(o_stall), 64'h1);
        @(negedge clk);
        rst_n = 1'b0;
        model_step();
        settle();
        chk("rstw_stall0", 64'(o_stall), 64'h0);
        chk("rstw_instret", o_instret, 64'h0);
        chk("rstw_wd", 64'(o_write_data), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 3'b010, 0, 1, 32'h5555_AAAA);
        settle();
        chk("late_ack_wr", 64'(o_wr), 64'h0);
        chk("late_ack_ce", 64'(o_ce), 64'h0);

        // Counter wrap from all-ones
        #1;
        force dut.instret_q = '1;
        #1;
        release dut.instret_q;
        e_instret = '1;
        drive(1, 0, 1, 4, 0, 32'h0000_0042, 0, 0, 0, 0);
        settle();
        chk("wrap_instret", o_instret, 64'h0);
        chk("wrap_ce", 64'(o_ce), 64'h1);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom),
                  5'($urandom), 2'($urandom), $urandom, 3'($urandom), 2'($urandom),
                  $urandom_range(0, 2) == 0, $urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
